// File: rtl/btn_cond.sv
// btn_cond: debounce and edge-strobe conditioner for raw board push-buttons.
// Optional auto-repeat on held buttons when BTN_REPEAT_EN is defined.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   i_btn      raw button pins (asynchronous, polarity set by ACTIVE_LOW)
//   o_level    debounced pressed state, 1 = pressed
//   o_press    one-clk strobe on accepted press (and auto-repeats if enabled)
//   o_release  one-clk strobe on accepted release
//   o_tick     one-clk debounce sample strobe, shareable with other blocks
//
// Build option:
//   BTN_REPEAT_EN  adds per-button auto-repeat of o_press while held,
//                  first after REPEAT_DELAY ticks, then every REPEAT_RATE.

module btn_cond #(
    parameter int NBTN         = 2,
    parameter int TICK_DIV     = 50000,
    parameter int DEB_TICKS    = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] i_btn,
    output logic [NBTN-1:0] o_level,
    output logic [NBTN-1:0] o_press,
    output logic [NBTN-1:0] o_release,
    output logic            o_tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(DEB_TICKS + 1);

    localparam logic [PW-1:0] P_RELOAD = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [CW-1:0] C_LAST   = CW'(DEB_TICKS);

    // Pin level of a released button.
    localparam logic [NBTN-1:0] IDLE_PIN = (ACTIVE_LOW != 0) ? '1 : '0;

    if (NBTN < 1 || TICK_DIV < 2 || DEB_TICKS < 1 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("btn_cond: illegal parameter value");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRESS_CHK = 2'd1,
        S_HELD      = 2'd2,
        S_REL_CHK   = 2'd3
    } state_t;

    // ------------------------------------------------------------
    // Sample-tick prescaler
    // ------------------------------------------------------------
    logic [PW-1:0] pcnt;
    logic          tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= P_RELOAD;
        end else if (pcnt == '0) begin
            pcnt <= P_RELOAD;
        end else begin
            pcnt <= pcnt - 1'b1;
        end
    end

    assign tick   = (pcnt == '0);
    assign o_tick = tick;

    // ------------------------------------------------------------
    // Input synchronizer; p = 1 means pressed regardless of polarity
    // ------------------------------------------------------------
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= IDLE_PIN;
            sync2 <= IDLE_PIN;
        end else begin
            sync1 <= i_btn;
            sync2 <= sync1;
        end
    end

    assign p = sync2 ^ IDLE_PIN;

    // ------------------------------------------------------------
    // Per-button debounce FSMs
    // ------------------------------------------------------------
    state_t        st  [NBTN];
    logic [CW-1:0] cnt [NBTN];

`ifdef BTN_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                          REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [RW-1:0] R_ONE   = RW'(1);
    localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_RATE  = RW'(REPEAT_RATE);

    // rfirst: the next repeat is the first one, so it waits REPEAT_DELAY.
    logic [RW-1:0]   rcnt [NBTN];
    logic [NBTN-1:0] rfirst;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBTN; b++) begin
                st[b]  <= S_IDLE;
                cnt[b] <= '0;
`ifdef BTN_REPEAT_EN
                rcnt[b] <= '0;
`endif
            end
`ifdef BTN_REPEAT_EN
            rfirst    <= '0;
`endif
            o_level   <= '0;
            o_press   <= '0;
            o_release <= '0;
        end else begin
            o_press   <= '0;
            o_release <= '0;
            for (int b = 0; b < NBTN; b++) begin
                unique case (st[b])
                    S_IDLE: begin
                        if (tick && p[b]) begin
                            // A single required sample accepts at once.
                            if (C_LAST == C_ONE) begin
                                st[b]      <= S_HELD;
                                o_level[b] <= 1'b1;
                                o_press[b] <= 1'b1;
`ifdef BTN_REPEAT_EN
                                rcnt[b]    <= '0;
                                rfirst[b]  <= 1'b1;
`endif
                            end else begin
                                st[b]  <= S_PRESS_CHK;
                                cnt[b] <= C_ONE;
                            end
                        end
                    end

                    S_PRESS_CHK: begin
                        if (tick) begin
                            if (!p[b]) begin
                                st[b] <= S_IDLE;
                            end else if (cnt[b] + C_ONE == C_LAST) begin
                                st[b]      <= S_HELD;
                                o_level[b] <= 1'b1;
                                o_press[b] <= 1'b1;
`ifdef BTN_REPEAT_EN
                                rcnt[b]    <= '0;
                                rfirst[b]  <= 1'b1;
`endif
                            end else begin
                                cnt[b] <= cnt[b] + C_ONE;
                            end
                        end
                    end

                    S_HELD: begin
                        if (tick) begin
                            if (!p[b]) begin
                                if (C_LAST == C_ONE) begin
                                    st[b]        <= S_IDLE;
                                    o_level[b]   <= 1'b0;
                                    o_release[b] <= 1'b1;
                                end else begin
                                    st[b]  <= S_REL_CHK;
                                    cnt[b] <= C_ONE;
                                end
                            end
`ifdef BTN_REPEAT_EN
                            else if (rcnt[b] + R_ONE ==
                                     (rfirst[b] ? R_DELAY : R_RATE)) begin
                                o_press[b] <= 1'b1;
                                rcnt[b]    <= '0;
                                rfirst[b]  <= 1'b0;
                            end else begin
                                rcnt[b] <= rcnt[b] + R_ONE;
                            end
`endif
                        end
                    end

                    S_REL_CHK: begin
                        // The repeat counter is left untouched here, so a
                        // bounce back to HELD resumes where it stopped.
                        if (tick) begin
                            if (p[b]) begin
                                st[b] <= S_HELD;
                            end else if (cnt[b] + C_ONE == C_LAST) begin
                                st[b]        <= S_IDLE;
                                o_level[b]   <= 1'b0;
                                o_release[b] <= 1'b1;
                            end else begin
                                cnt[b] <= cnt[b] + C_ONE;
                            end
                        end
                    end

                    default: begin
                        st[b]      <= S_IDLE;
                        cnt[b]     <= '0;
                        o_level[b] <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
